// File: rtl/npu_sequencer.sv
// Dot-product sequencer: fetches N_ELEM weights and inputs over an I2C command port, then MACs, saturates and writes back a 16-bit result.
// Latency: one command per 2+ cycles plus target delays, N_ELEM MAC cycles, two store writes. Optional ReLU via NPU_SEQ_RELU_EN.
// Backpressure: cmd_valid and its fields are held until cmd_ready; only one command is outstanding until rsp_valid.
module npu_sequencer #(
    parameter int         N_ELEM   = 4,
    parameter logic [6:0] DEV_ADDR = 7'h50
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic        cmd_rw,
    output logic [6:0]  cmd_dev,
    output logic [7:0]  cmd_reg,
    output logic [7:0]  cmd_wdata,
    input  logic        rsp_valid,
    input  logic [7:0]  rsp_rdata,
    input  logic        rsp_nack,
    output logic [15:0] result,
    output logic        busy,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        IDLE, LOAD_W, LOAD_X, MAC, STORE_H, STORE_L, DONE, ERROR
    } state_t;

    localparam logic [3:0] LAST = 4'(N_ELEM - 1);

    state_t             state, state_n;
    logic               vld_q, pend_q, abort_q;
    logic [3:0]         idx;
    logic signed [19:0] acc, acc_next;
    logic signed [15:0] prod;
    logic signed [7:0]  w [16];
    logic signed [7:0]  x [16];
    logic [15:0]        sat_val, fin_val;
    logic               cmd_state, accept, rsp_take, kill, last, start_run;

    assign cmd_state = (state == LOAD_W) || (state == LOAD_X) || (state == STORE_H) || (state == STORE_L);
    assign accept    = vld_q && cmd_ready;
    assign rsp_take  = rsp_valid && pend_q;
    assign kill      = stop || abort_q;
    assign last      = (idx == LAST);
    assign start_run = ((state == IDLE) || (state == DONE) || (state == ERROR)) && start && !stop;

    assign prod     = 16'(w[idx]) * 16'(x[idx]);
    assign acc_next = acc + 20'(prod);

    always_comb begin
        sat_val = acc_next[15:0];
        if (acc_next > 20'sd32767)
            sat_val = 16'h7FFF;
        else if (acc_next < -20'sd32768)
            sat_val = 16'h8000;
`ifdef NPU_SEQ_RELU_EN
        fin_val = sat_val[15] ? 16'h0000 : sat_val;
`else
        fin_val = sat_val;
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            error <= 1'b0;
        end else begin
            state <= state_n;
            busy  <= (state_n == LOAD_W) || (state_n == LOAD_X) || (state_n == MAC) ||
                     (state_n == STORE_H) || (state_n == STORE_L);
            done  <= (state_n == DONE);
            error <= (state_n == ERROR);
        end
    end

    always_comb begin
        state_n   = state;
        cmd_valid = vld_q && !reset;
        cmd_dev   = reset ? 7'h00 : DEV_ADDR;
        cmd_rw    = 1'b0;
        cmd_reg   = 8'h00;
        cmd_wdata = 8'h00;
        case (state)
            IDLE, DONE, ERROR: if (start && !stop) state_n = LOAD_W;
            LOAD_W, LOAD_X, STORE_H, STORE_L: begin
                if (rsp_take) begin
                    // A pending abort outranks a NACK on the same response.
                    if (kill)
                        state_n = IDLE;
                    else if (rsp_nack)
                        state_n = ERROR;
                    else if (state == LOAD_W)
                        state_n = last ? LOAD_X : LOAD_W;
                    else if (state == LOAD_X)
                        state_n = last ? MAC : LOAD_X;
                    else if (state == STORE_H)
                        state_n = STORE_L;
                    else
                        state_n = DONE;
                end else if (stop && !pend_q && !accept) begin
                    state_n = IDLE;
                end
            end
            MAC: begin
                if (stop)
                    state_n = IDLE;
                else if (last)
                    state_n = STORE_H;
            end
            default: state_n = IDLE;
        endcase
        if (!reset) begin
            case (state)
                LOAD_W:  begin cmd_rw = 1'b1; cmd_reg = {4'h0, idx}; end
                LOAD_X:  begin cmd_rw = 1'b1; cmd_reg = {4'h1, idx}; end
                STORE_H: begin cmd_reg = 8'h20; cmd_wdata = result[15:8]; end
                STORE_L: begin cmd_reg = 8'h21; cmd_wdata = result[7:0]; end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            vld_q   <= 1'b0;
            pend_q  <= 1'b0;
            abort_q <= 1'b0;
            idx     <= '0;
            acc     <= '0;
            result  <= '0;
            for (int i = 0; i < 16; i++) begin
                w[i] <= '0;
                x[i] <= '0;
            end
        end else begin
            if (start_run) begin
                vld_q   <= 1'b0;
                pend_q  <= 1'b0;
                abort_q <= 1'b0;
                idx     <= '0;
                acc     <= '0;
            end
            if (cmd_state) begin
                if (accept) begin
                    vld_q  <= 1'b0;
                    pend_q <= 1'b1;
                end else if (stop) begin
                    vld_q <= 1'b0;
                end else if (!vld_q && !pend_q && !abort_q) begin
                    vld_q <= 1'b1;
                end
                // Stop with a command in flight is remembered until its response returns.
                if (stop && (pend_q || accept))
                    abort_q <= 1'b1;
                if (rsp_take) begin
                    pend_q  <= 1'b0;
                    abort_q <= 1'b0;
                    if (!kill && !rsp_nack) begin
                        if (state == LOAD_W) w[idx] <= rsp_rdata;
                        if (state == LOAD_X) x[idx] <= rsp_rdata;
                        idx <= last ? 4'd0 : idx + 4'd1;
                    end
                end
            end
            if (state == MAC && !stop) begin
                acc <= acc_next;
                idx <= last ? 4'd0 : idx + 4'd1;
                if (last)
                    result <= fin_val;
            end
        end
    end

endmodule

// File: tb/tb_npu_sequencer.sv
// Self-checking bench for npu_sequencer: I2C target model with random delays plus a dot-product reference model.
module tb_npu_sequencer;
    localparam int N = 4;

    logic        clock = 1'b0;
    logic        reset, start, stop;
    logic        cmd_valid, cmd_ready, cmd_rw;
    logic [6:0]  cmd_dev;
    logic [7:0]  cmd_reg, cmd_wdata, rsp_rdata;
    logic        rsp_valid, rsp_nack;
    logic [15:0] result;
    logic        busy, done, error;

    always #5 clock = ~clock;

    npu_sequencer #(.N_ELEM(N), .DEV_ADDR(7'h50)) dut (
        .clock(clock), .reset(reset), .start(start), .stop(stop),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
        .cmd_dev(cmd_dev), .cmd_reg(cmd_reg), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_nack(rsp_nack),
        .result(result), .busy(busy), .done(done), .error(error)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Target model state, shared with the directed sequence.
    logic [7:0]  mem [256];
    logic [16:0] log_q [$];
    int          run_cmd_n  = 0;
    int          nack_at    = -1;
    int          rsp_delay  = -1;
    bit          hold_ready = 1'b0;

    initial begin : target
        bit          pend, pend_nack, hs, prev_wait;
        int          pend_wait;
        logic [16:0] cap, prev_f;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        cmd_ready = 0; rsp_valid = 0; rsp_nack = 0; rsp_rdata = 0;
        pend = 0; pend_nack = 0; hs = 0; prev_wait = 0; pend_wait = 0;
        cap = '0; prev_f = '0;
        forever begin
            @(negedge clock);
            rsp_valid = 0; rsp_nack = 0; rsp_rdata = 0;
            if (reset) begin
                pend = 0; hs = 0; cmd_ready = 0; prev_wait = 0;
            end else begin
                if (prev_wait && cmd_valid)
                    chk("cmd_stable", 32'({cmd_rw, cmd_reg, cmd_wdata}), 32'(prev_f));
                if (hs) begin
                    log_q.push_back(cap);
                    pend      = 1;
                    pend_nack = (run_cmd_n == nack_at);
                    pend_wait = (rsp_delay < 0) ? int'($urandom_range(0, 3)) : rsp_delay;
                    run_cmd_n++;
                end
                hs = 0;
                if (pend) begin
                    chk("no_vld_while_pending", 32'(cmd_valid), 0);
                    if (pend_wait == 0) begin
                        rsp_valid = 1;
                        rsp_nack  = pend_nack;
                        rsp_rdata = mem[cap[15:8]];
                        if (!cap[16] && !pend_nack) mem[cap[15:8]] = cap[7:0];
                        pend = 0;
                    end else begin
                        pend_wait--;
                    end
                end
                cmd_ready = 0;
                if (cmd_valid && !pend && !hold_ready && $urandom_range(0, 2) != 0) begin
                    cmd_ready = 1;
                    hs        = 1;
                    cap       = {cmd_rw, cmd_reg, cmd_wdata};
                end
                prev_wait = cmd_valid && !cmd_ready;
                prev_f    = {cmd_rw, cmd_reg, cmd_wdata};
            end
        end
    end

    logic [7:0] wv [N];
    logic [7:0] xv [N];

    function automatic logic [15:0] model();
        int s = 0;
        for (int i = 0; i < N; i++) s += $signed(wv[i]) * $signed(xv[i]);
        if (s > 32767)  s = 32767;
        if (s < -32768) s = -32768;
`ifdef NPU_SEQ_RELU_EN
        if (s < 0) s = 0;
`endif
        return 16'(s);
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic kick();
        for (int i = 0; i < N; i++) begin
            mem[8'(i)]      = wv[i];
            mem[8'(16 + i)] = xv[i];
        end
        log_q.delete();
        run_cmd_n = 0;
        start = 1;
        tick();
        start = 0;
    endtask

    task automatic wait_end(input string tag);
        int n = 0;
        while (!(done || error) && n < 3000) begin
            tick();
            n++;
        end
        chk({tag, "_timeout"}, 32'(n < 3000), 1);
    endtask

    task automatic run_and_check(input string tag, output logic [15:0] exp);
        exp = model();
        kick();
        wait_end(tag);
        chk({tag, "_result"}, 32'(result), 32'(exp));
        chk({tag, "_flags"}, 32'({busy, done, error}), 32'(3'b010));
        chk({tag, "_ncmd"}, 32'(log_q.size()), 32'(2 * N + 2));
        chk({tag, "_rd_w2"}, 32'(log_q[2]), 32'({1'b1, 8'h02, 8'h00}));
        chk({tag, "_rd_x0"}, 32'(log_q[N]), 32'({1'b1, 8'h10, 8'h00}));
        chk({tag, "_wr_hi"}, 32'(log_q[2 * N]), 32'({1'b0, 8'h20, exp[15:8]}));
        chk({tag, "_wr_lo"}, 32'(log_q[2 * N + 1]), 32'({1'b0, 8'h21, exp[7:0]}));
        tick(); tick();
        chk({tag, "_done_hold"}, 32'(done), 1);
    endtask

    initial begin : seq
        logic [15:0] last_exp, tmp;
        int          n, vc, sz;
        logic [7:0]  reg0;
        reset = 1; start = 0; stop = 0;
        tick(); tick(); tick();
        chk("rst_outputs", 32'({cmd_valid, busy, done, error, cmd_reg, cmd_dev}), 0);
        chk("rst_result", 32'(result), 0);
        reset = 0;
        tick();
        chk("dev_addr", 32'(cmd_dev), 32'h50);

        for (int i = 0; i < N; i++) begin wv[i] = 8'(i + 1); xv[i] = 8'(i + 5); end
        run_and_check("normal", last_exp);
        chk("normal_70", 32'(result), 70);

        for (int i = 0; i < N; i++) begin wv[i] = 8'h80; xv[i] = 8'h80; end
        run_and_check("sat_pos", last_exp);

        for (int i = 0; i < N; i++) begin wv[i] = 8'h7F; xv[i] = 8'h80; end
        run_and_check("sat_neg", last_exp);

        for (int i = 0; i < N; i++) begin wv[i] = 8'h00; xv[i] = 8'h00; end
        wv[0] = 8'hFF; xv[0] = 8'd5;
        run_and_check("neg", last_exp);

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < N; i++) begin wv[i] = 8'($urandom); xv[i] = 8'($urandom); end
            run_and_check("rand", last_exp);
        end

        // NACK on the third weight read.
        nack_at = 2;
        kick();
        wait_end("nack");
        chk("nack_flags", 32'({busy, done, error}), 32'(3'b001));
        chk("nack_result", 32'(result), 32'(last_exp));
        chk("nack_ncmd", 32'(log_q.size()), 3);
        vc = 0;
        for (int i = 0; i < 20; i++) begin tick(); if (cmd_valid) vc++; end
        chk("nack_quiet", 32'(vc), 0);
        nack_at = -1;

        // Stop while the first input read is outstanding.
        rsp_delay = 6;
        kick();
        n = 0;
        while (log_q.size() < N + 1 && n < 500) begin tick(); n++; end
        chk("stop_reach_lx", 32'(log_q.size()), 32'(N + 1));
        stop = 1;
        n = 0;
        while (!rsp_valid && n < 30) begin tick(); n++; end
        chk("stop_rsp_seen", 32'(rsp_valid), 1);
        chk("stop_idle", 32'({busy, cmd_valid, done, error}), 0);
        stop = 0;
        rsp_delay = -1;
        sz = log_q.size();
        vc = 0;
        for (int i = 0; i < 20; i++) begin tick(); if (cmd_valid) vc++; end
        chk("stop_quiet", 32'(vc), 0);
        chk("stop_ncmd", 32'(log_q.size()), 32'(sz));
        chk("stop_result", 32'(result), 32'(last_exp));

        // Stop outranks start; stop with nothing outstanding aborts next cycle.
        hold_ready = 1;
        start = 1; stop = 1;
        tick();
        chk("stop_over_start", 32'(busy), 0);
        stop = 0;
        tick();
        start = 0;
        chk("start_busy", 32'(busy), 1);
        n = 0;
        while (!cmd_valid && n < 20) begin tick(); n++; end
        chk("vld_rise", 32'(cmd_valid), 1);
        stop = 1;
        tick();
        chk("stop_no_pend", 32'({busy, cmd_valid}), 0);
        stop = 0;

        // Ready held low: command held stable, then reset mid-wait.
        start = 1;
        tick();
        start = 0;
        n = 0;
        while (!cmd_valid && n < 20) begin tick(); n++; end
        reg0 = cmd_reg;
        chk("hold_first_reg", 32'(reg0), 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_vld", 32'({cmd_valid, cmd_rw, cmd_reg}), 32'({1'b1, 1'b1, reg0}));
        end
        reset = 1;
        tick();
        chk("rst_mid_vld", 32'({cmd_valid, busy}), 0);
        chk("rst_mid_result", 32'(result), 0);
        reset = 0;
        hold_ready = 0;
        tick();

        for (int i = 0; i < N; i++) begin wv[i] = 8'($urandom); xv[i] = 8'($urandom); end
        run_and_check("recover", tmp);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/npu_sequencer.md
NPU_SEQUENCER -- requirements
Module: npu_sequencer

Interface
REQ-001 Parameters SHALL be: N_ELEM, default 4, vector length (1..16); DEV_ADDR, default 7'h50, I2C target device address.
REQ-002 clock  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 start  in  1  level; sampled in IDLE, DONE and ERROR to begin a run.
REQ-005 stop  in  1  level; abort request.
REQ-006 cmd_valid  out  1  I2C command valid.
REQ-007 cmd_ready  in  1  I2C master accepts the command.
REQ-008 cmd_rw  out  1  1=read byte, 0=write byte.
REQ-009 cmd_dev  out  7  device address, always DEV_ADDR.
REQ-010 cmd_reg  out  8  target register pointer.
REQ-011 cmd_wdata  out  8  write byte.
REQ-012 rsp_valid  in  1  one-cycle pulse, command complete.
REQ-013 rsp_rdata  in  8  read byte, valid with rsp_valid.
REQ-014 rsp_nack  in  1  target NACKed, valid with rsp_valid.
REQ-015 result  out  16  signed result of the last completed run.
REQ-016 busy, done, error  out  1 each  status flags.

Function
REQ-017 The FSM SHALL have states IDLE, LOAD_W, LOAD_X, MAC, STORE_H, STORE_L, DONE and ERROR.
REQ-018 IDLE/DONE/ERROR with start=1 and stop=0 SHALL go to LOAD_W next cycle, clear done/error, set busy, and zero the index and accumulator.
REQ-019 LOAD_W SHALL issue N_ELEM reads: cmd_reg=8'h00+i, storing rsp_rdata into signed weight w[i]; it then SHALL enter LOAD_X.
REQ-020 LOAD_X SHALL issue N_ELEM reads: cmd_reg=8'h10+i, storing into signed input x[i]; it then SHALL enter MAC.
REQ-021 Handshake: cmd_valid and cmd fields SHALL stay stable until the cycle cmd_valid&cmd_ready; cmd_valid SHALL then be 0 until rsp_valid; at most one command SHALL be outstanding.
REQ-022 The next command SHALL assert no earlier than the cycle after rsp_valid.
REQ-023 rsp_valid with rsp_nack=1 SHALL go to ERROR: error=1, busy=0, result unchanged.
REQ-024 MAC SHALL take exactly N_ELEM cycles, adding w[i]*x[i] (signed 8x8 -> 16) per cycle into a 20-bit signed accumulator.
REQ-025 On leaving MAC the accumulator SHALL be saturated to 16-bit signed (max 16'h7FFF, min 16'h8000) into the result register.
REQ-026 STORE_H SHALL write result[15:8] to cmd_reg=8'h20; STORE_L SHALL then write result[7:0] to cmd_reg=8'h21; after the STORE_L response the FSM SHALL enter DONE.
REQ-027 DONE SHALL set done=1 and busy=0; done SHALL hold until the next run starts or reset.
REQ-028 stop=1 with no command outstanding SHALL go to IDLE next cycle with busy=0 and cmd_valid=0.
REQ-029 stop=1 with a command outstanding (accepted, no response yet) SHALL go to IDLE on the rsp_valid cycle and discard the response data.
REQ-030 stop SHALL have priority over start, and over nack when both occur on the same rsp_valid.
REQ-031 A NACK during STORE_H or STORE_L SHALL go to ERROR, keeping the new result value.

Reset
REQ-032 reset SHALL force IDLE, and clear cmd_valid, busy, done, error, result, accumulator, index and all w/x registers to 0.
REQ-033 A reset asserted mid-transaction SHALL abandon the transaction immediately; a later rsp_valid SHALL be ignored in IDLE.
REQ-034 All outputs other than result and the status flags SHALL be 0 while in reset.

Configuration
REQ-035 With macro NPU_SEQ_RELU_EN defined, a negative saturated result SHALL be replaced by 0 before it is registered and stored.
REQ-036 Without NPU_SEQ_RELU_EN, the signed saturated value SHALL be stored unchanged.

Verification
REQ-037 Normal run with N_ELEM=4, w={1,2,3,4}, x={5,6,7,8}: result=16'd70, writes 8'h00 then 8'h46, done=1.
REQ-038 Saturation: all w=x=8'h80 (-128), N_ELEM=4 -> sum 65536 -> result=16'h7FFF.
REQ-039 Negative sum: w={-1,0,0,0}, x={5,0,0,0} -> result=16'hFFFB; with NPU_SEQ_RELU_EN the result is 16'h0000.
REQ-040 NACK on the third weight read -> error=1, busy=0, no further cmd_valid, and result stays at its previous value.
REQ-041 stop during LOAD_X with a command outstanding -> IDLE on the rsp_valid cycle, busy=0, no later commands issued.
REQ-042 cmd_ready held 0 for 5 cycles -> cmd_valid/cmd_reg stay stable throughout; reset mid-wait -> cmd_valid=0 next cycle.
